// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register: DEPTH elastic stages of {write, quarter, data} with
// valid/ready handshake, bubble collapsing, synchronous flush, occupancy and forwarding taps.
module wb_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int QTR_W  = 2,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_write,
    input  logic [QTR_W-1:0]        in_quarter,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_write,
    output logic [QTR_W-1:0]        out_quarter,
    output logic [DATA_W-1:0]       out_data,
    output logic [DEPTH-1:0]        fwd_write,
    output logic [DEPTH*QTR_W-1:0]  fwd_quarter,
    output logic [DEPTH*DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]        occupancy
);

    logic [DEPTH-1:0]  stg_valid;
    logic [DEPTH-1:0]  stg_write;
    logic [DEPTH-1:0]  stg_load;
    logic [QTR_W-1:0]  stg_quarter [DEPTH];
    logic [DATA_W-1:0] stg_data    [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              valid_q, valid_d;
            logic              write_q, write_d;
            logic [QTR_W-1:0]  quarter_q, quarter_d;
            logic [DATA_W-1:0] data_q, data_d;
            logic              load;
            logic              src_valid;
            logic              src_write;
            logic [QTR_W-1:0]  src_quarter;
            logic [DATA_W-1:0] src_data;

            // A stage can take a new entry when it is empty or its content moves on;
            // an empty stage anywhere downstream therefore frees everything behind it.
            if (gi == DEPTH - 1) begin : g_tail
                assign load = !valid_q | out_ready;
            end else begin : g_body
                assign load = !valid_q | g_stage[gi+1].load;
            end

            if (gi == 0) begin : g_src_input
                assign src_valid   = in_valid;
                assign src_write   = in_write;
                assign src_quarter = in_quarter;
                assign src_data    = in_data;
            end else begin : g_src_prev
                assign src_valid   = stg_valid[gi-1];
                assign src_write   = stg_write[gi-1];
                assign src_quarter = stg_quarter[gi-1];
                assign src_data    = stg_data[gi-1];
            end

            always_comb begin
                valid_d   = valid_q;
                write_d   = write_q;
                quarter_d = quarter_q;
                data_d    = data_q;
                if (load) begin
                    valid_d = src_valid;
                    if (src_valid) begin
                        write_d   = src_write;
                        quarter_d = src_quarter;
                        data_d    = src_data;
                    end
                end
                // Flush wins over any load; payload simply holds.
                if (flush) begin
                    valid_d   = 1'b0;
                    write_d   = write_q;
                    quarter_d = quarter_q;
                    data_d    = data_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q   <= 1'b0;
                    write_q   <= 1'b0;
                    quarter_q <= '0;
                    data_q    <= '0;
                end else begin
                    valid_q   <= valid_d;
                    write_q   <= write_d;
                    quarter_q <= quarter_d;
                    data_q    <= data_d;
                end
            end

            assign stg_valid[gi]   = valid_q;
            assign stg_write[gi]   = write_q;
            assign stg_quarter[gi] = quarter_q;
            assign stg_data[gi]    = data_q;
            assign stg_load[gi]    = load;

            assign fwd_write[gi]                     = valid_q & write_q;
            assign fwd_quarter[gi*QTR_W +: QTR_W]    = quarter_q;
            assign fwd_data[gi*DATA_W +: DATA_W]     = data_q;
        end
    endgenerate

    assign in_ready = stg_load[0];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = stg_valid[DEPTH-1] & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - CNT_W'(1);
        end
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy   = occ_q;
    assign out_valid   = stg_valid[DEPTH-1];
    assign out_write   = stg_valid[DEPTH-1] & stg_write[DEPTH-1];
    assign out_quarter = stg_quarter[DEPTH-1];
    assign out_data    = stg_data[DEPTH-1];

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: DEPTH=1/2/3 instances share stimulus; a per-instance queue
// scoreboard checks ordering, in_ready and occupancy every cycle, scenario tasks check details.
module tb_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_write = 1'b0;
    logic [1:0]  in_quarter = 2'd0;
    logic [15:0] in_data = 16'd0;
    logic        out_ready = 1'b0;

    logic [2:0]       ir, ov, ow;
    logic [2:0][1:0]  oq;
    logic [2:0][15:0] od;

    logic [0:0]  fw1;  logic [1:0] fq1;  logic [15:0] fd1;  logic [0:0] occ1;
    logic [1:0]  fw2;  logic [3:0] fq2;  logic [31:0] fd2;  logic [1:0] occ2;
    logic [2:0]  fw3;  logic [5:0] fq3;  logic [47:0] fd3;  logic [1:0] occ3;
    logic [2:0][2:0] occ_v;

    assign occ_v[0] = {2'b00, occ1};
    assign occ_v[1] = {1'b0, occ2};
    assign occ_v[2] = {1'b0, occ3};

    int checks = 0;
    int errors = 0;
    logic [18:0] sb [3][$];

    always #5 clk = ~clk;

    wb_pipe_reg #(.DATA_W(16), .QTR_W(2), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_write(in_write),
        .in_quarter(in_quarter), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_write(ow[0]),
        .out_quarter(oq[0]), .out_data(od[0]),
        .fwd_write(fw1), .fwd_quarter(fq1), .fwd_data(fd1), .occupancy(occ1)
    );

    wb_pipe_reg #(.DATA_W(16), .QTR_W(2), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_write(in_write),
        .in_quarter(in_quarter), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_write(ow[1]),
        .out_quarter(oq[1]), .out_data(od[1]),
        .fwd_write(fw2), .fwd_quarter(fq2), .fwd_data(fd2), .occupancy(occ2)
    );

    wb_pipe_reg #(.DATA_W(16), .QTR_W(2), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_write(in_write),
        .in_quarter(in_quarter), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_write(ow[2]),
        .out_quarter(oq[2]), .out_data(od[2]),
        .fwd_write(fw3), .fwd_quarter(fq3), .fwd_data(fd3), .occupancy(occ3)
    );

    // Scoreboard: pre-edge sampling on the falling edge; pop, then push, then flush.
    always @(negedge clk) begin
        logic [18:0] exp_e;
        logic        exp_rdy;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                exp_rdy = (sb[k].size() < k + 1) || out_ready;
                checks++;
                if (ir[k] !== exp_rdy) begin
                    errors++;
                    $display("FAIL in_ready d%0d: got %b expected %b", k + 1, ir[k], exp_rdy);
                end
                checks++;
                if (occ_v[k] !== 3'(sb[k].size())) begin
                    errors++;
                    $display("FAIL occupancy d%0d: got %0d expected %0d", k + 1, occ_v[k], sb[k].size());
                end
                if (!ov[k]) begin
                    checks++;
                    if (ow[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL out_write_gate d%0d: got %b expected 0", k + 1, ow[k]);
                    end
                end
                if (ov[k] && out_ready) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_out d%0d: got data %h expected no entry", k + 1, od[k]);
                    end else begin
                        exp_e = sb[k].pop_front();
                        if ({ow[k], oq[k], od[k]} !== exp_e) begin
                            errors++;
                            $display("FAIL out_entry d%0d: got %h expected %h", k + 1,
                                     {ow[k], oq[k], od[k]}, exp_e);
                        end
                    end
                end
                if (in_valid && ir[k]) sb[k].push_back({in_write, in_quarter, in_data});
                if (flush) sb[k].delete();
            end
            if ((in_valid && ir[2]) || (ov[2] && out_ready))
                $display("cycle t=%0t d3 in=%b/%h out=%b/%h occ=%0d", $time,
                         in_valid && ir[2], in_data, ov[2] && out_ready, od[2], occ3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int k = 0; k < 3; k++) sb[k].delete();
    endtask

    task automatic push(input logic [15:0] d, input logic w, input logic [1:0] q);
        in_valid = 1'b1;
        in_data = d;
        in_write = w;
        in_quarter = q;
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12 && ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 || ov != 3'b000); n++)
            tick();
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 || ov !== 3'b000) begin
            errors++;
            $display("FAIL drain: got %0d pending ov=%b expected 0 pending ov=000",
                     sb[0].size() + sb[1].size() + sb[2].size(), ov);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ov[k], ow[k], oq[k], od[k], occ_v[k]} !== 23'd0) begin
                errors++;
                $display("FAIL reset_out d%0d: got %h expected 0", k + 1, {ov[k], ow[k], oq[k], od[k], occ_v[k]});
            end
        end
        checks++;
        if ({fw1, fw2, fw3, fq1, fq2, fq3, fd1, fd2, fd3} !== '0) begin
            errors++;
            $display("FAIL reset_fwd: got nonzero taps expected 0");
        end
        clear_sb();
        rst = 1'b0;
        #1;
        checks++;
        if (ir !== 3'b111) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 111", ir);
        end
    endtask

    task automatic test_stream_d1();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'h1111 + 16'(i), 1'b1, 2'(i));
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 16'h1111 + 16'(i)) begin
                errors++;
                $display("FAIL stream_d1: got v=%b %h expected v=1 %h", ov[0], od[0], 16'h1111 + 16'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL stream_d1_empty: got %b expected 0", ov[0]);
        end
        drain();
    endtask

    task automatic test_fill_d3();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h00A0 + 16'(i), 1'b1, 2'(i));
        in_valid = 1'b1;
        in_data = 16'h00A3;
        for (int r = 0; r < 3; r++) begin
            #1;
            checks++;
            if (occ3 !== 2'd3 || ir[2] !== 1'b0 || ov[2] !== 1'b1 || od[2] !== 16'h00A0) begin
                errors++;
                $display("FAIL fill_d3: got occ=%0d rdy=%b v=%b %h expected occ=3 rdy=0 v=1 00a0",
                         occ3, ir[2], ov[2], od[2]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        push(16'h00C0, 1'b0, 2'd1);
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (ov[2] !== 1'b1 || occ3 !== 2'd1 || fw3 !== 3'b000) begin
            errors++;
            $display("FAIL bubble_tail: got v=%b occ=%0d fw=%b expected v=1 occ=1 fw=000", ov[2], occ3, fw3);
        end
        in_valid = 1'b1;
        in_data = 16'h00B0;
        in_write = 1'b1;
        in_quarter = 2'd2;
        #1;
        checks++;
        if (ir[2] !== 1'b1) begin
            errors++;
            $display("FAIL bubble_ready0: got %b expected 1", ir[2]);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (fw3 !== 3'b001 || fd3[15:0] !== 16'h00B0 || ir[2] !== 1'b1) begin
            errors++;
            $display("FAIL bubble_s0: got fw=%b d=%h rdy=%b expected fw=001 d=00b0 rdy=1", fw3, fd3[15:0], ir[2]);
        end
        tick();
        checks++;
        if (fw3 !== 3'b010 || fd3[31:16] !== 16'h00B0 || fq3[3:2] !== 2'd2 || ir[2] !== 1'b1 || occ3 !== 2'd2) begin
            errors++;
            $display("FAIL bubble_s1: got fw=%b d=%h q=%0d rdy=%b occ=%0d expected fw=010 d=00b0 q=2 rdy=1 occ=2",
                     fw3, fd3[31:16], fq3[3:2], ir[2], occ3);
        end
        drain();
    endtask

    task automatic test_flush_d2();
        out_ready = 1'b0;
        push(16'h00D0, 1'b1, 2'd0);
        push(16'h00D1, 1'b1, 2'd1);
        checks++;
        if (occ2 !== 2'd2 || ir[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occ2, ir[1]);
        end
        flush = 1'b1;
        push(16'h00D2, 1'b1, 2'd2);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (occ2 !== 2'd0 || ov[1] !== 1'b0 || fw2 !== 2'b00 || occ3 !== 2'd0 || fw3 !== 3'b000) begin
            errors++;
            $display("FAIL flush_d2: got occ=%0d v=%b fw=%b occ3=%0d expected occ=0 v=0 fw=00 occ3=0",
                     occ2, ov[1], fw2, occ3);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h00E0 + 16'(i), 1'(i), 2'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = 16'h00E3 + 16'(i);
            #1;
            checks++;
            if (ir[2] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: got %b expected 1", ir[2]);
            end
            tick();
            checks++;
            if (occ3 !== 2'd3) begin
                errors++;
                $display("FAIL b2b_occ: got %0d expected 3", occ3);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h00F0 + 16'(i), 1'b1, 2'd3);
        in_valid = 1'b0;
        checks++;
        if (ov[2] !== 1'b1 || fw3 !== 3'b111) begin
            errors++;
            $display("FAIL pre_reset: got v=%b fw=%b expected v=1 fw=111", ov[2], fw3);
        end
        #2;
        rst = 1'b1;
        clear_sb();
        #1;
        checks++;
        if (ov !== 3'b000 || ow !== 3'b000 || od[2] !== 16'd0 || oq[2] !== 2'd0 || occ3 !== 2'd0
            || fw3 !== 3'b000 || fd3 !== 48'd0 || fq3 !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h occ=%0d fw=%b expected all 0", ov, od[2], occ3, fw3);
        end
        rst = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush = ($urandom_range(28) == 0);
            in_data = 16'($urandom);
            in_write = 1'($urandom);
            in_quarter = 2'($urandom);
            tick();
        end
        flush = 1'b0;
        drain();
    endtask

    initial begin
        #2 rst = 1'b1;
        test_reset();
        test_stream_d1();
        test_fill_d3();
        test_bubble();
        test_flush_d2();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
